// File: rtl/psum_requant_packer.sv
// psum_requant_packer: bias-add, requantize and clamp PE opsums to uint8, then
// pack four bytes per 32-bit word (byte k in [8k+7:8k]) toward the GLB.
module psum_requant_packer #(
  parameter int DATA_BITS  = 32,
  parameter int NUM_CH     = 4,
  parameter int SCALE_BITS = 16,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [SCALE_BITS-1:0] cfg_scale,
  input  logic [4:0]            cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  cfg_relu,
  input  logic [1:0]            cfg_ch_num,
  input  logic [CNT_BITS-1:0]   cfg_total,
  input  logic                  bias_we,
  input  logic [1:0]            bias_addr,
  input  logic [31:0]           bias_wdata,
  input  logic [DATA_BITS-1:0]  psum_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  output logic [31:0]           out_data,
  output logic [3:0]            out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int SUM_W  = DATA_BITS + 1;
  localparam int PROD_W = SUM_W + SCALE_BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [SCALE_BITS-1:0]       scale_q;
  logic [4:0]                  shift_q;
  logic [7:0]                  zp_q;
  logic                        relu_q;
  logic [1:0]                  ch_num_q;
  logic [CNT_BITS-1:0]         total_q;
  logic [CNT_BITS-1:0]         accept_cnt;
  logic [1:0]                  ch_idx;
  logic [NUM_CH-1:0][31:0]     bias_tbl;

  logic                        stall, fire, fire_last;
  logic [1:0]                  vld_pipe, last_pipe;
  logic signed [SUM_W-1:0]     sum_q;
  logic signed [PROD_W-1:0]    prod_q;
  logic [3:0][7:0]             pack_q, pack_nx;
  logic [1:0]                  pack_cnt;
  logic [3:0]                  keep_nx;

  assign stall      = out_valid && !out_ready;
  assign psum_ready = (state == RUN) && !stall;
  assign fire       = psum_valid && psum_ready;
  assign fire_last  = fire && (accept_cnt == total_q - CNT_BITS'(1));
  assign busy       = (state != IDLE);

  // Control FSM; bias table and cfg are only writable while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scale_q    <= '0;
      shift_q    <= '0;
      zp_q       <= '0;
      relu_q     <= 1'b0;
      ch_num_q   <= '0;
      total_q    <= '0;
      accept_cnt <= '0;
      ch_idx     <= '0;
      bias_tbl   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bias_we) bias_tbl[bias_addr] <= bias_wdata;
          if (cfg_en) begin
            scale_q    <= cfg_scale;
            shift_q    <= cfg_shift;
            zp_q       <= cfg_zp;
            relu_q     <= cfg_relu;
            ch_num_q   <= cfg_ch_num;
            total_q    <= (cfg_total == '0) ? CNT_BITS'(1) : cfg_total;
            accept_cnt <= '0;
            ch_idx     <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            accept_cnt <= accept_cnt + CNT_BITS'(1);
            ch_idx     <= (ch_idx == ch_num_q) ? 2'd0 : ch_idx + 2'd1;
          end
          if (fire_last) state <= DRAIN;
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [SUM_W-1:0]  psum_ext, bias_ext;
  logic signed [PROD_W-1:0] sum_ext, scale_ext, rnd, r;
  logic [PROD_W:0]          v;
  logic [7:0]               byte_c;

  always_comb begin
    psum_ext  = {{(SUM_W-DATA_BITS){psum_in[DATA_BITS-1]}}, psum_in};
    bias_ext  = {{(SUM_W-32){bias_tbl[ch_idx][31]}}, bias_tbl[ch_idx]};
    sum_ext   = {{(PROD_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    scale_ext = {{(PROD_W-SCALE_BITS){1'b0}}, scale_q};
    // Round half up, then arithmetic shift
    rnd = '0;
    if (shift_q != 5'd0) rnd = PROD_W'(1) << (shift_q - 5'd1);
    r = (prod_q + rnd) >>> shift_q;
    if (relu_q && r[PROD_W-1]) r = '0;
    v = {r[PROD_W-1], r} + {{(PROD_W-7){1'b0}}, zp_q};
    if (v[PROD_W])            byte_c = 8'h00;
    else if (|v[PROD_W-1:8])  byte_c = 8'hFF;
    else                      byte_c = v[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      sum_q     <= '0;
      prod_q    <= '0;
    end else if (!stall) begin
      vld_pipe  <= {vld_pipe[0], fire};
      last_pipe <= {last_pipe[0], fire_last};
      sum_q     <= psum_ext + bias_ext;
      prod_q    <= sum_ext * scale_ext;
    end
  end

  always_comb begin
    pack_nx           = pack_q;
    pack_nx[pack_cnt] = byte_c;
    for (int k = 0; k < 4; k++) keep_nx[k] = (k <= int'(pack_cnt));
  end

  // Separate accumulator keeps out_data stable while the next word fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q    <= '0;
      pack_cnt  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE && cfg_en) begin
        pack_q   <= '0;
        pack_cnt <= '0;
      end else if (!stall && vld_pipe[1]) begin
        if (pack_cnt == 2'd3 || last_pipe[1]) begin
          out_data  <= pack_nx;
          out_keep  <= keep_nx;
          out_last  <= last_pipe[1];
          out_valid <= 1'b1;
          pack_q    <= '0;
          pack_cnt  <= '0;
        end else begin
          pack_q   <= pack_nx;
          pack_cnt <= pack_cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_psum_requant_packer.sv
// Directed bench for psum_requant_packer: single-psum requant table plus
// multi-word, stall and mid-job reset sequences.
module tb_psum_requant_packer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_en = 1'b0, cfg_relu = 1'b0;
  logic [15:0] cfg_scale = '0, cfg_total = '0;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic [1:0]  cfg_ch_num = '0, bias_addr = '0;
  logic        bias_we = 1'b0;
  logic [31:0] bias_wdata = '0, psum_in = '0;
  logic        psum_valid = 1'b0, psum_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last, out_valid, out_ready = 1'b1, busy, done;

  psum_requant_packer dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
    .cfg_ch_num(cfg_ch_num), .cfg_total(cfg_total), .bias_we(bias_we),
    .bias_addr(bias_addr), .bias_wdata(bias_wdata), .psum_in(psum_in),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int dn, lat_acc, lat_first, n_ps, n_exp;
  logic [31:0] ps[8];
  logic [31:0] exp_d[4];
  logic [3:0]  exp_k[4];
  logic        exp_l[4];

  typedef struct {
    logic [15:0] scale; logic [4:0] shift; logic [7:0] zp; logic relu;
    logic [15:0] total; logic [31:0] bias; logic [31:0] psum; logic [7:0] exp;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s bound expired", nm);
  endtask

  task automatic set_bias(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bias_we = 1'b1; bias_addr = a; bias_wdata = d;
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp,
                         input logic rl, input logic [1:0] chn, input logic [15:0] tot,
                         input int hold_len, input bit spoil, input string tag);
    int g, g2, nw, held, acyc;
    bit got, rdy, seen;
    @(negedge clk);
    cfg_scale = sc; cfg_shift = sh; cfg_zp = zp; cfg_relu = rl;
    cfg_ch_num = chn; cfg_total = tot; cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    dn = 0; lat_first = -1; lat_acc = -1; out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < n_ps; i++) begin
          psum_in = ps[i]; psum_valid = 1'b1;
          if (spoil && i == 0) begin
            bias_we = 1'b1; bias_addr = 2'd0; bias_wdata = 32'd999;
            cfg_en = 1'b1; cfg_zp = 8'd0; cfg_total = 16'd1;
          end
          got = 1'b0; g = 0;
          while (!got && g < 300) begin
            #2; rdy = psum_ready; acyc = cyc;
            @(posedge clk);
            if (rdy) begin
              got = 1'b1;
              if (i == 3) lat_acc = acyc;
            end
            @(negedge clk);
            bias_we = 1'b0; cfg_en = 1'b0;
            g++;
          end
          if (!got) bound_fail({tag, "_drv"});
        end
        psum_valid = 1'b0;
      end
      begin
        nw = 0; g2 = 0; seen = 1'b0; held = 0;
        while (nw < n_exp && g2 < 300) begin
          @(negedge clk); #1;
          if (out_valid && lat_first < 0) lat_first = cyc;
          if (out_valid && hold_len > 0) seen = 1'b1;
          out_ready = !(seen && held < hold_len);
          if (!out_ready) held++;
          #1;
          if (out_valid && !out_ready) begin
            chk({tag, "_stall_ready"}, 32'(psum_ready), 32'd0);
            chk({tag, "_stall_hold"}, out_data, exp_d[nw]);
          end
          if (out_valid && out_ready) begin
            chk({tag, "_data"}, out_data, exp_d[nw]);
            chk({tag, "_keep"}, 32'(out_keep), 32'(exp_k[nw]));
            chk({tag, "_last"}, 32'(out_last), 32'(exp_l[nw]));
            nw++;
          end
          if (done) dn++;
          g2++;
        end
        if (nw < n_exp) bound_fail({tag, "_words"});
      end
    join
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      if (done) dn++;
    end
    chk({tag, "_done"}, 32'(dn), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic load_t1();
    ps[0] = 32'hFFFFFFF6; ps[1] = 32'd0; ps[2] = 32'd127; ps[3] = 32'd200; n_ps = 4;
    exp_d[0] = 32'hFFFF8076; exp_k[0] = 4'hF; exp_l[0] = 1'b1; n_exp = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{16'd3,     5'd2,  8'd128, 1'b0, 16'd1, 32'd2,        32'd40,       8'hA0};
    vt[1]  = '{16'd1,     5'd0,  8'd128, 1'b1, 16'd1, 32'd0,        32'hFFFFFFF6, 8'h80};
    vt[2]  = '{16'd1,     5'd0,  8'd128, 1'b0, 16'd1, 32'd0,        32'hFFFFFC18, 8'h00};
    vt[3]  = '{16'd1,     5'd0,  8'd128, 1'b0, 16'd1, 32'd0,        32'd200,      8'hFF};
    vt[4]  = '{16'd1,     5'd1,  8'd0,   1'b0, 16'd1, 32'd0,        32'd5,        8'h03};
    vt[5]  = '{16'd1,     5'd1,  8'd10,  1'b0, 16'd1, 32'd0,        32'hFFFFFFFB, 8'h08};
    vt[6]  = '{16'd1,     5'd1,  8'd10,  1'b0, 16'd1, 32'd0,        32'hFFFFFFFD, 8'h09};
    vt[7]  = '{16'd65535, 5'd16, 8'd0,   1'b0, 16'd1, 32'd0,        32'd100,      8'h64};
    vt[8]  = '{16'd2,     5'd31, 8'd0,   1'b0, 16'd1, 32'd0,        32'h7FFFFFFF, 8'h02};
    vt[9]  = '{16'd1,     5'd25, 8'd0,   1'b0, 16'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'h80};
    vt[10] = '{16'd1,     5'd0,  8'd255, 1'b0, 16'd1, 32'd0,        32'd1,        8'hFF};
    vt[11] = '{16'd1,     5'd0,  8'd0,   1'b1, 16'd0, 32'd0,        32'd50,       8'h32};

    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_keep", 32'(out_keep), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_psum_ready", 32'(psum_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four psums into one full word, with pipeline latency
    set_bias(2'd0, 32'd0);
    load_t1();
    run_job(16'd1, 5'd0, 8'd128, 1'b0, 2'd0, 16'd4, 0, 1'b0, "t1");
    chk("t1_latency", 32'(lat_first - lat_acc), 32'd3);

    for (int i = 0; i < 12; i++) begin
      set_bias(2'd0, vt[i].bias);
      ps[0] = vt[i].psum; n_ps = 1;
      exp_d[0] = {24'h0, vt[i].exp}; exp_k[0] = 4'b0001; exp_l[0] = 1'b1; n_exp = 1;
      run_job(vt[i].scale, vt[i].shift, vt[i].zp, vt[i].relu, 2'd0, vt[i].total, 0, 1'b0,
              $sformatf("vec%0d", i));
    end

    // Interleaved channels: bias index wraps at ch_num
    set_bias(2'd0, 32'd5);
    set_bias(2'd1, 32'hFFFFFFFB);
    for (int i = 0; i < 4; i++) ps[i] = 32'd10;
    n_ps = 4;
    exp_d[0] = 32'h050F050F; exp_k[0] = 4'hF; exp_l[0] = 1'b1; n_exp = 1;
    run_job(16'd1, 5'd0, 8'd0, 1'b0, 2'd1, 16'd4, 0, 1'b0, "t4");

    // Partial final word
    set_bias(2'd0, 32'd0);
    for (int i = 0; i < 6; i++) ps[i] = 32'(i + 1);
    n_ps = 6;
    exp_d[0] = 32'h04030201; exp_k[0] = 4'hF;   exp_l[0] = 1'b0;
    exp_d[1] = 32'h00000605; exp_k[1] = 4'b0011; exp_l[1] = 1'b1; n_exp = 2;
    run_job(16'd1, 5'd0, 8'd0, 1'b0, 2'd0, 16'd6, 0, 1'b0, "part");

    // Backpressure: out_ready low for 6 cycles on the first word
    for (int i = 0; i < 8; i++) ps[i] = 32'(i + 1);
    n_ps = 8;
    exp_d[0] = 32'h04030201; exp_k[0] = 4'hF; exp_l[0] = 1'b0;
    exp_d[1] = 32'h08070605; exp_k[1] = 4'hF; exp_l[1] = 1'b1; n_exp = 2;
    run_job(16'd1, 5'd0, 8'd0, 1'b0, 2'd0, 16'd8, 6, 1'b0, "t5");

    // Reset mid-job with a word pending
    @(negedge clk);
    cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd128; cfg_relu = 1'b0;
    cfg_ch_num = 2'd0; cfg_total = 16'd8; cfg_en = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    cfg_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      psum_in = 32'(i); psum_valid = 1'b1;
      @(negedge clk);
    end
    psum_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("t6_pending", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(psum_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; dn = 0;
    repeat (5) begin
      @(negedge clk); #2;
      if (done) dn++;
    end
    chk("t6_no_done", 32'(dn), 32'd0);

    // Test 1 again; bias/cfg writes during the job must be ignored
    set_bias(2'd0, 32'd0);
    load_t1();
    run_job(16'd1, 5'd0, 8'd128, 1'b0, 2'd0, 16'd4, 0, 1'b1, "t6r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
